// File: rtl/modulo_convertidor_binario_bcd_secuencial_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package paquete_bcd;

  typedef enum logic [1:0] {
    LIBRE,
    DESPLAZAR,
    TERMINADO
  } tipo_estado_bcd;

  localparam int         ANCHO_DIGITO  = 4;
  localparam logic [3:0] UMBRAL_AJUSTE = 4'd5;
  localparam logic [3:0] SUMA_AJUSTE   = 4'd3;

  // Decimal digits needed for an ancho-bit magnitude: ceil(ancho * log10(2)).
  // log10(2) ~= 0.30103; the product is never an exact integer for ancho > 0,
  // so rounding up with integer arithmetic is exact for practical widths.
  function automatic int digitos_minimos(input int ancho);
    return (ancho * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/modulo_convertidor_binario_bcd_secuencial_ajuste.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module modulo_ajuste_digito
  import paquete_bcd::*;
(
  input  logic [ANCHO_DIGITO-1:0] digito_entrada,
  output logic [ANCHO_DIGITO-1:0] digito_salida
);

  // Add 3 so the following left shift carries correctly into the next decade.
  always_comb begin
    digito_salida = digito_entrada;
    if (digito_entrada >= UMBRAL_AJUSTE) begin
      digito_salida = digito_entrada + SUMA_AJUSTE;
    end
  end

endmodule

// File: rtl/modulo_convertidor_binario_bcd_secuencial.sv
// Multi-cycle binary-to-BCD converter (double dabble), one operand bit per clock,
// valid/ready handshake on input and output.
// Optional feature macro: BCD_SIGNO_EN (two's complement operand, sign on salida_signo).
module modulo_convertidor_binario_bcd_secuencial
  import paquete_bcd::*;
#(
  parameter int ANCHO_ENTRADA = 8,
  parameter int DIGITOS       = 3
) (
  input  logic                            reloj,
  input  logic                            reset,
  input  logic                            entrada_valida,
  output logic                            entrada_lista,
  input  logic [ANCHO_ENTRADA-1:0]        entrada_binario,
  output logic                            salida_valida,
  input  logic                            salida_aceptada,
  output logic [ANCHO_DIGITO*DIGITOS-1:0] salida_bcd,
  output logic                            salida_signo
);

  localparam int ANCHO_BCD    = ANCHO_DIGITO * DIGITOS;
  localparam int ANCHO_CUENTA = $clog2(ANCHO_ENTRADA + 1);
  localparam logic [ANCHO_CUENTA-1:0] ULTIMA_CUENTA = ANCHO_CUENTA'(ANCHO_ENTRADA - 1);

  if (ANCHO_ENTRADA < 2) begin : g_chequeo_ancho
    $error("ANCHO_ENTRADA must be at least 2");
  end
  if (DIGITOS < digitos_minimos(ANCHO_ENTRADA)) begin : g_chequeo_digitos
    $error("DIGITOS too small to hold the largest converted value");
  end

  tipo_estado_bcd             estado_q, estado_d;
  logic [ANCHO_CUENTA-1:0]    cuenta_q, cuenta_d;
  logic [ANCHO_BCD-1:0]       acum_q, acum_d;
  logic [ANCHO_ENTRADA-1:0]   despl_q, despl_d;
  logic [ANCHO_BCD-1:0]       bcd_q, bcd_d;
  logic                       signo_captura_q, signo_captura_d;
  logic                       signo_q, signo_d;
  logic                       valida_q, valida_d;
  logic                       lista_q, lista_d;

  logic [ANCHO_BCD-1:0]               acum_ajustado;
  logic [ANCHO_BCD+ANCHO_ENTRADA-1:0] desplazado;
  logic [ANCHO_ENTRADA-1:0]           magnitud;
  logic                               signo_entrada;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
    modulo_ajuste_digito u_ajuste (
      .digito_entrada (acum_q[g*ANCHO_DIGITO +: ANCHO_DIGITO]),
      .digito_salida  (acum_ajustado[g*ANCHO_DIGITO +: ANCHO_DIGITO])
    );
  end

  // Operand seen as a magnitude plus sign; the most negative value maps to 2^(N-1).
  always_comb begin
`ifdef BCD_SIGNO_EN
    signo_entrada = entrada_binario[ANCHO_ENTRADA-1];
    magnitud      = signo_entrada ? (~entrada_binario + ANCHO_ENTRADA'(1)) : entrada_binario;
`else
    signo_entrada = 1'b0;
    magnitud      = entrada_binario;
`endif
  end

  // Next-state logic: capture, shift with digit correction, then hold the result.
  always_comb begin
    estado_d        = estado_q;
    cuenta_d        = cuenta_q;
    acum_d          = acum_q;
    despl_d         = despl_q;
    bcd_d           = bcd_q;
    signo_captura_d = signo_captura_q;
    signo_d         = signo_q;
    valida_d        = valida_q;
    lista_d         = lista_q;
    desplazado      = {acum_ajustado, despl_q} << 1;
    case (estado_q)
      LIBRE: begin
        if (entrada_valida && lista_q) begin
          despl_d         = magnitud;
          acum_d          = '0;
          cuenta_d        = '0;
          signo_captura_d = signo_entrada;
          lista_d         = 1'b0;
          estado_d        = DESPLAZAR;
        end
      end
      DESPLAZAR: begin
        acum_d   = desplazado[ANCHO_BCD+ANCHO_ENTRADA-1 -: ANCHO_BCD];
        despl_d  = desplazado[ANCHO_ENTRADA-1:0];
        cuenta_d = cuenta_q + ANCHO_CUENTA'(1);
        if (cuenta_q == ULTIMA_CUENTA) begin
          bcd_d    = desplazado[ANCHO_BCD+ANCHO_ENTRADA-1 -: ANCHO_BCD];
          signo_d  = signo_captura_q;
          valida_d = 1'b1;
          estado_d = TERMINADO;
        end
      end
      TERMINADO: begin
        if (salida_aceptada) begin
          valida_d = 1'b0;
          lista_d  = 1'b1;
          estado_d = LIBRE;
        end
      end
      default: begin
        estado_d = LIBRE;
        valida_d = 1'b0;
        lista_d  = 1'b1;
      end
    endcase
  end

  // State and registered handshake/result outputs; reset aborts any conversion.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado_q        <= LIBRE;
      cuenta_q        <= '0;
      acum_q          <= '0;
      despl_q         <= '0;
      bcd_q           <= '0;
      signo_captura_q <= 1'b0;
      signo_q         <= 1'b0;
      valida_q        <= 1'b0;
      lista_q         <= 1'b1;
    end else begin
      estado_q        <= estado_d;
      cuenta_q        <= cuenta_d;
      acum_q          <= acum_d;
      despl_q         <= despl_d;
      bcd_q           <= bcd_d;
      signo_captura_q <= signo_captura_d;
      signo_q         <= signo_d;
      valida_q        <= valida_d;
      lista_q         <= lista_d;
    end
  end

  assign entrada_lista = lista_q;
  assign salida_valida = valida_q;
  assign salida_bcd    = bcd_q;
  assign salida_signo  = signo_q;

endmodule

// File: tb/tb_modulo_convertidor_binario_bcd_secuencial.sv
// Randomized self-checking bench for the sequential binary-to-BCD converter.
// Expected digits come from plain decimal arithmetic on the operand value.
module tb_modulo_convertidor_binario_bcd_secuencial;

   localparam int W = 8;
   localparam int D = 3;

   logic           reloj = 1'b0;
   logic           reset;
   logic           entradaValida;
   logic           entradaLista;
   logic [W-1:0]   entradaBinario;
   logic           salidaValida;
   logic           salidaAceptada;
   logic [4*D-1:0] salidaBcd;
   logic           salidaSigno;

   int             vectors = 0;
   int             miscompares = 0;
   logic [4*D-1:0] ultimoBcd;
   logic           ultimoSigno;

   modulo_convertidor_binario_bcd_secuencial #(
      .ANCHO_ENTRADA (W),
      .DIGITOS       (D)
   ) dut (
      .reloj           (reloj),
      .reset           (reset),
      .entrada_valida  (entradaValida),
      .entrada_lista   (entradaLista),
      .entrada_binario (entradaBinario),
      .salida_valida   (salidaValida),
      .salida_aceptada (salidaAceptada),
      .salida_bcd      (salidaBcd),
      .salida_signo    (salidaSigno)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 reloj = ~reloj;

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observado, input logic [31:0] esperado);
      vectors++;
      if (observado !== esperado) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observado, esperado, $time);
      end
   endtask

   // Operand sign under the configured number format.
   function automatic logic modeloSigno(input logic [W-1:0] x);
`ifdef BCD_SIGNO_EN
      return x[W-1];
`else
      return 1'b0;
`endif
   endfunction

   // Absolute value of the operand as a plain integer.
   function automatic int unsigned modeloMagnitud(input logic [W-1:0] x);
      int unsigned v;
      v = int'(x);
      if (modeloSigno(x)) v = (1 << W) - v;
      return v;
   endfunction

   // Decimal digits by repeated division, digit 0 in the low nibble.
   function automatic logic [4*D-1:0] modeloBcd(input int unsigned valor);
      logic [4*D-1:0] r;
      int unsigned v;
      r = '0;
      v = valor;
      for (int d = 0; d < D; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // One full conversion: handshake in, latency/result checks, optional stall, handshake out.
   task automatic applyStimulus(input logic [W-1:0] valor, input int retenciones);
      int espera;
      logic [4*D-1:0] esperado;
      espera = 0;
      while (entradaLista !== 1'b1 && espera < 20) begin
         @(negedge reloj);
         espera++;
      end
      if (espera >= 20) begin
         checkOutput("lista_timeout", 32'(entradaLista), 32'd1);
         return;
      end
      entradaBinario = valor;
      entradaValida  = 1'b1;
      @(negedge reloj);
      entradaValida  = 1'b0;
      entradaBinario = W'($urandom);
      checkOutput("lista_ocupada", 32'(entradaLista), 32'd0);
      for (int i = 1; i <= W; i++) begin
         salidaAceptada = 1'($urandom_range(0, 1));
         @(negedge reloj);
         checkOutput("valida_latencia", 32'(salidaValida), (i == W) ? 32'd1 : 32'd0);
         if (i < W) checkOutput("bcd_previo", 32'(salidaBcd), 32'(ultimoBcd));
      end
      salidaAceptada = 1'b0;
      esperado = modeloBcd(modeloMagnitud(valor));
      checkOutput("bcd_resultado", 32'(salidaBcd), 32'(esperado));
      checkOutput("signo_resultado", 32'(salidaSigno), 32'(modeloSigno(valor)));
      ultimoBcd   = esperado;
      ultimoSigno = modeloSigno(valor);
      for (int h = 0; h < retenciones; h++) begin
         entradaValida  = 1'b1;
         entradaBinario = W'(7);
         @(negedge reloj);
         entradaValida = 1'b0;
         checkOutput("valida_retenida", 32'(salidaValida), 32'd1);
         checkOutput("lista_retenida", 32'(entradaLista), 32'd0);
         checkOutput("bcd_retenido", 32'(salidaBcd), 32'(ultimoBcd));
         checkOutput("signo_retenido", 32'(salidaSigno), 32'(ultimoSigno));
      end
      salidaAceptada = 1'b1;
      @(negedge reloj);
      salidaAceptada = 1'b0;
      checkOutput("valida_liberada", 32'(salidaValida), 32'd0);
      checkOutput("lista_liberada", 32'(entradaLista), 32'd1);
      checkOutput("bcd_mantenido", 32'(salidaBcd), 32'(ultimoBcd));
   endtask

   // Start a conversion and abort it with reset after three shifts.
   task automatic applyResetMidConversion(input logic [W-1:0] valor);
      entradaBinario = valor;
      entradaValida  = 1'b1;
      @(negedge reloj);
      entradaValida = 1'b0;
      repeat (3) @(negedge reloj);
      reset = 1'b1;
      #1;
      checkOutput("rst_valida", 32'(salidaValida), 32'd0);
      checkOutput("rst_lista", 32'(entradaLista), 32'd1);
      checkOutput("rst_bcd", 32'(salidaBcd), 32'd0);
      checkOutput("rst_signo", 32'(salidaSigno), 32'd0);
      @(negedge reloj);
      reset       = 1'b0;
      ultimoBcd   = '0;
      ultimoSigno = 1'b0;
   endtask

   // Hard stop in case the sequence itself stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed cases, then random operands with random stalls, then reset abort.
   initial begin
      logic [W-1:0] dirigidos [8];
      dirigidos = '{8'd0, 8'd255, 8'd99, 8'd100, 8'h80, 8'hFF, 8'h7F, 8'd1};
      reset          = 1'b1;
      entradaValida  = 1'b0;
      salidaAceptada = 1'b0;
      entradaBinario = '0;
      ultimoBcd      = '0;
      ultimoSigno    = 1'b0;
      repeat (2) @(negedge reloj);
      checkOutput("reset_lista", 32'(entradaLista), 32'd1);
      checkOutput("reset_valida", 32'(salidaValida), 32'd0);
      checkOutput("reset_bcd", 32'(salidaBcd), 32'd0);
      checkOutput("reset_signo", 32'(salidaSigno), 32'd0);
      reset = 1'b0;
      @(negedge reloj);
      foreach (dirigidos[i]) applyStimulus(dirigidos[i], 0);
      applyStimulus(8'd255, 5);
      for (int n = 0; n < 30; n++) begin
         applyStimulus(W'($urandom), $urandom_range(0, 3));
      end
      applyResetMidConversion(8'd200);
      applyStimulus(8'd42, 0);
      applyStimulus(8'd128, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
